// File: rtl/boss_enemy_controller.sv
// rtl/boss_enemy_controller.sv - patrolling boss enemy with bullet hit detection,
// post-hit invulnerability, timed death phase and kill strobe.
module boss_enemy_controller #(
   parameter int N_BULLETS  = 8,
   parameter int BW         = 10,
   parameter int HP_MAX     = 10,
   parameter int SPR_W      = 32,
   parameter int SPR_H      = 32,
   parameter int BUL_SZ     = 8,
   parameter int SPAWN_X    = 320,
   parameter int SPAWN_Y    = 50,
   parameter int STEP       = 2,
   parameter int MOVE_DIV   = 500000,
   parameter int MARGIN     = 10,
   parameter int SCREEN_W   = 640,
   parameter int INVULN_CYC = 250000,
   parameter int DYING_CYC  = 2000000,
   localparam int HPW       = $clog2(HP_MAX + 1)
) (
   input  logic                    clk25,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [N_BULLETS*BW-1:0] bullet_x_flat,
   input  logic [N_BULLETS*BW-1:0] bullet_y_flat,
   input  logic [N_BULLETS-1:0]    bullet_active_flat,
   output logic [BW-1:0]           enemy_x,
   output logic [BW-1:0]           enemy_y,
   output logic [HPW-1:0]          enemy_hp,
   output logic                    enemy_alive,
   output logic                    enemy_flash,
   output logic                    enemy_dying,
   output logic [N_BULLETS-1:0]    bullet_hit,
   output logic                    kill_pulse
);

   localparam int XMAX = SCREEN_W - SPR_W - MARGIN;
   localparam int TMAX = (INVULN_CYC > DYING_CYC) ? INVULN_CYC : DYING_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int MW   = $clog2(MOVE_DIV + 1);

   typedef enum logic [2:0] {IDLE, ALIVE, HURT, DYING, DEAD} state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        x_q, x_d;
   logic                 dir_left_q, dir_left_d;
   logic [HPW-1:0]       hp_q, hp_d;
   logic [MW-1:0]        mcnt_q, mcnt_d;
   logic [TW-1:0]        tmr_q, tmr_d;
   logic [N_BULLETS-1:0] hit_q, hit_d;
   logic                 kill_q, kill_d;

   logic [N_BULLETS-1:0] overlap;
   logic [BW-1:0]        x_mv;
   logic                 dir_mv;
   logic [MW-1:0]        mcnt_mv;

   // Box overlap in BW+1 bits so edge sums near the top of the range never wrap.
   for (genvar i = 0; i < N_BULLETS; i++) begin : g_hit
      logic [BW:0] bx, by, ex, ey;
      assign bx = {1'b0, bullet_x_flat[i*BW +: BW]};
      assign by = {1'b0, bullet_y_flat[i*BW +: BW]};
      assign ex = {1'b0, x_q};
      assign ey = {1'b0, BW'(SPAWN_Y)};
      assign overlap[i] = bullet_active_flat[i]
                       && (bx + (BW+1)'(BUL_SZ) >= ex) && (bx <= ex + (BW+1)'(SPR_W - 1))
                       && (by + (BW+1)'(BUL_SZ) >= ey) && (by <= ey + (BW+1)'(SPR_H - 1));
   end

   always_comb begin
      mcnt_mv = mcnt_q + MW'(1);
      x_mv    = x_q;
      dir_mv  = dir_left_q;
      if (mcnt_q == MW'(MOVE_DIV - 1)) begin
         mcnt_mv = '0;
         if (!dir_left_q) begin
            if (int'(x_q) + STEP >= XMAX) begin
               x_mv   = BW'(XMAX);
               dir_mv = 1'b1;
            end else begin
               x_mv = x_q + BW'(STEP);
            end
         end else begin
            if (int'(x_q) <= MARGIN + STEP) begin
               x_mv   = BW'(MARGIN);
               dir_mv = 1'b0;
            end else begin
               x_mv = x_q - BW'(STEP);
            end
         end
      end
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= BW'(SPAWN_X);
         dir_left_q <= 1'b0;
         hp_q       <= '0;
         mcnt_q     <= '0;
         tmr_q      <= '0;
         hit_q      <= '0;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         dir_left_q <= dir_left_d;
         hp_q       <= hp_d;
         mcnt_q     <= mcnt_d;
         tmr_q      <= tmr_d;
         hit_q      <= hit_d;
         kill_q     <= kill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      dir_left_d = dir_left_q;
      hp_d       = hp_q;
      mcnt_d     = mcnt_q;
      tmr_d      = tmr_q;
      hit_d      = '0;
      kill_d     = 1'b0;
      if (!enable) begin
         state_d    = IDLE;
         x_d        = BW'(SPAWN_X);
         dir_left_d = 1'b0;
         hp_d       = '0;
         mcnt_d     = '0;
         tmr_d      = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = ALIVE;
               hp_d       = HPW'(HP_MAX);
               x_d        = BW'(SPAWN_X);
               dir_left_d = 1'b0;
               mcnt_d     = '0;
               tmr_d      = '0;
            end
            ALIVE: begin
               x_d        = x_mv;
               dir_left_d = dir_mv;
               mcnt_d     = mcnt_mv;
               if (|overlap) begin
                  hit_d = overlap;
                  tmr_d = '0;
                  if (hp_q > HPW'(1)) begin
                     hp_d    = hp_q - HPW'(1);
                     state_d = HURT;
                  end else begin
                     hp_d    = '0;
                     kill_d  = 1'b1;
                     state_d = DYING;
                  end
               end
            end
            HURT: begin
               x_d        = x_mv;
               dir_left_d = dir_mv;
               mcnt_d     = mcnt_mv;
               hit_d      = overlap;
               if (tmr_q == TW'(INVULN_CYC - 1)) begin
                  tmr_d   = '0;
                  state_d = ALIVE;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            DYING: begin
               if (tmr_q == TW'(DYING_CYC - 1)) begin
                  tmr_d   = '0;
                  state_d = DEAD;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
            DEAD: begin
               hp_d = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      enemy_alive = (state_q == ALIVE) || (state_q == HURT);
      enemy_flash = (state_q == HURT);
      enemy_dying = (state_q == DYING);
   end

   assign enemy_x    = x_q;
   assign enemy_y    = BW'(SPAWN_Y);
   assign enemy_hp   = hp_q;
   assign bullet_hit = hit_q;
   assign kill_pulse = kill_q;

endmodule

// File: tb/tb_boss_enemy_controller.sv
// tb/tb_boss_enemy_controller.sv - scoreboard bench for boss_enemy_controller.
`timescale 1ns/1ps
module tb_boss_enemy_controller;

   localparam int NB = 8;
   localparam int BW = 10;

   logic            clk25 = 1'b0;
   logic            rst;
   logic            enable;
   logic [NB*BW-1:0] bullet_x_flat, bullet_y_flat;
   logic [NB-1:0]   bullet_active_flat;
   logic [BW-1:0]   enemy_x, enemy_y;
   logic [3:0]      enemy_hp;
   logic            enemy_alive, enemy_flash, enemy_dying, kill_pulse;
   logic [NB-1:0]   bullet_hit;

   boss_enemy_controller #(.MOVE_DIV(4), .INVULN_CYC(8), .DYING_CYC(12)) dut (
      .clk25(clk25), .rst(rst), .enable(enable),
      .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
      .bullet_active_flat(bullet_active_flat),
      .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_hp(enemy_hp),
      .enemy_alive(enemy_alive), .enemy_flash(enemy_flash), .enemy_dying(enemy_dying),
      .bullet_hit(bullet_hit), .kill_pulse(kill_pulse)
   );

   always #5 clk25 = ~clk25;

   typedef struct {
      string      tag;
      bit         chk_x;
      logic [9:0] x;
      logic [7:0] hit;
      logic [3:0] hp;
      logic       alive, flash, dying, kill;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   k = 0;
   int   hp_m;
   int   xk, max_x, min_x;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input string tag, input bit cx, input int x, input logic [7:0] hit,
                               input int hp, input logic al, input logic fl, input logic dy, input logic kl);
      exp_t e;
      e.tag = tag; e.chk_x = cx; e.x = 10'(x); e.hit = hit; e.hp = 4'(hp);
      e.alive = al; e.flash = fl; e.dying = dy; e.kill = kl;
      return e;
   endfunction

   // Bounce path for a spawn at 320 moving right, 2 px per 4 cycles, between 10 and 598.
   function automatic int exp_mx(input int kk);
      int s;
      s = kk / 4;
      if (s <= 139) return 320 + 2 * s;
      else if (s <= 433) return 598 - 2 * (s - 139);
      else return 10 + 2 * (s - 433);
   endfunction

   task automatic tick();
      @(posedge clk25);
      #1;
      k++;
   endtask

   task automatic cyc(input exp_t e);
      exp_t got;
      sb.push_back(e);
      tick();
      got = sb.pop_front();
      if (got.chk_x) chk({got.tag, "_x"}, 32'(enemy_x), 32'(got.x));
      chk({got.tag, "_y"}, 32'(enemy_y), 32'd50);
      chk({got.tag, "_hit"}, 32'(bullet_hit), 32'(got.hit));
      chk({got.tag, "_hp"}, 32'(enemy_hp), 32'(got.hp));
      chk({got.tag, "_alive"}, 32'(enemy_alive), 32'(got.alive));
      chk({got.tag, "_flash"}, 32'(enemy_flash), 32'(got.flash));
      chk({got.tag, "_dying"}, 32'(enemy_dying), 32'(got.dying));
      chk({got.tag, "_kill"}, 32'(kill_pulse), 32'(got.kill));
   endtask

   task automatic set_bullet(input int i, input int bx, input int by, input logic act);
      bullet_x_flat[i*BW +: BW] = 10'(bx);
      bullet_y_flat[i*BW +: BW] = 10'(by);
      bullet_active_flat[i] = act;
   endtask

   task automatic clear_bullets();
      bullet_x_flat = '0;
      bullet_y_flat = '0;
      bullet_active_flat = '0;
   endtask

   task automatic spawn();
      enable = 1'b0;
      cyc(mk("idle", 1, 320, 8'h00, 0, 0, 0, 0, 0));
      enable = 1'b1;
      cyc(mk("spawn", 1, 320, 8'h00, 10, 1, 0, 0, 0));
      k = 0;
      hp_m = 10;
   endtask

   // Each hit is followed by waiting out the invulnerability window unless it kills.
   task automatic run_hits(input int n);
      for (int h = 0; h < n; h++) begin
         clear_bullets();
         set_bullet(0, exp_mx(k) + 12, 60, 1'b1);
         hp_m--;
         if (hp_m == 0)
            cyc(mk("kill_hit", 1, exp_mx(k + 1), 8'h01, 0, 0, 0, 1, 1));
         else
            cyc(mk("hit", 1, exp_mx(k + 1), 8'h01, hp_m, 1, 1, 0, 0));
         clear_bullets();
         if (hp_m != 0) begin
            for (int j = 0; j < 7; j++) cyc(mk("invuln", 0, 0, 8'h00, hp_m, 1, 1, 0, 0));
            cyc(mk("invuln_end", 0, 0, 8'h00, hp_m, 1, 0, 0, 0));
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      clear_bullets();
      #12;
      chk("rst_x", 32'(enemy_x), 32'd320);
      chk("rst_hp", 32'(enemy_hp), 32'd0);
      chk("rst_alive", 32'(enemy_alive), 32'd0);
      chk("rst_hit", 32'(bullet_hit), 32'd0);
      @(negedge clk25);
      rst = 1'b0;

      // First hit one cycle after spawn, then edge-of-box and hurt-phase absorption.
      set_bullet(3, 330, 60, 1'b1);
      spawn();
      cyc(mk("first_hit", 1, 320, 8'h08, 9, 1, 1, 0, 0));
      clear_bullets();
      set_bullet(6, 311, 60, 1'b1);
      set_bullet(7, 351, 81, 1'b1);
      set_bullet(1, 320, 41, 1'b1);
      set_bullet(2, 320, 42, 1'b1);
      set_bullet(3, 352, 60, 1'b1);
      set_bullet(4, 330, 60, 1'b0);
      cyc(mk("edges", 1, 320, 8'h84, 9, 1, 1, 0, 0));
      clear_bullets();
      set_bullet(1, 332, 60, 1'b1);
      cyc(mk("hurt_absorb", 1, 320, 8'h02, 9, 1, 1, 0, 0));
      clear_bullets();
      while (k < 8) cyc(mk("hurt_hold", 0, 0, 8'h00, 9, 1, 1, 0, 0));
      cyc(mk("hurt_end", 0, 0, 8'h00, 9, 1, 0, 0, 0));
      set_bullet(0, exp_mx(k) + 12, 60, 1'b1);
      cyc(mk("second_hit", 0, 0, 8'h01, 8, 1, 1, 0, 0));
      clear_bullets();
      enable = 1'b0;
      cyc(mk("abort", 1, 320, 8'h00, 0, 0, 0, 0, 0));

      // Two overlapping bullets cost a single HP; a distant active bullet is ignored.
      spawn();
      set_bullet(0, 330, 60, 1'b1);
      set_bullet(5, 340, 70, 1'b1);
      set_bullet(2, 100, 300, 1'b1);
      cyc(mk("double_hit", 1, 320, 8'h21, 9, 1, 1, 0, 0));
      clear_bullets();

      // Asynchronous reset mid-ALIVE with hp=4, observed between clock edges.
      spawn();
      run_hits(6);
      chk("pre_rst_hp", 32'(enemy_hp), 32'd4);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_x", 32'(enemy_x), 32'd320);
      chk("async_rst_hp", 32'(enemy_hp), 32'd0);
      chk("async_rst_alive", 32'(enemy_alive), 32'd0);
      chk("async_rst_flash", 32'(enemy_flash), 32'd0);
      @(negedge clk25);
      rst = 1'b0;

      // Kill, death phase ignoring bullets, DEAD hold, then respawn.
      spawn();
      run_hits(10);
      xk = exp_mx(k);
      set_bullet(0, xk + 12, 60, 1'b1);
      for (int j = 0; j < 11; j++) cyc(mk("dying", 1, xk, 8'h00, 0, 0, 0, 1, 0));
      cyc(mk("dead", 0, 0, 8'h00, 0, 0, 0, 0, 0));
      for (int j = 0; j < 3; j++) cyc(mk("dead_hold", 0, 0, 8'h00, 0, 0, 0, 0, 0));
      clear_bullets();
      spawn();

      // Patrol to the right clamp and back to the left clamp.
      max_x = 0;
      min_x = 1023;
      for (int j = 0; j < 1740; j++) begin
         cyc(mk("patrol", 1, exp_mx(k + 1), 8'h00, 10, 1, 0, 0, 0));
         if (int'(enemy_x) > max_x) max_x = int'(enemy_x);
         if (k > 556 && int'(enemy_x) < min_x) min_x = int'(enemy_x);
      end
      chk("patrol_max", 32'(max_x), 32'd598);
      chk("patrol_min", 32'(min_x), 32'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
